regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/regfile_sb.sv | 117 +++++++++++
 tb/tb_regfile_sb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg -- shared constants and packed-port helpers for the
// register file with scoreboard.
//
// Contents:
//   DEFAULT_WORD_SIZE : default data width in bits
//   DEFAULT_NUM_REGS  : default register count
//   packed_width()    : total width of a bus packing several equal ports
//   slice_lo()        : low bit of one port inside such a packed bus
package regfile_sb_pkg;

  localparam int DEFAULT_WORD_SIZE = 32;
  localparam int DEFAULT_NUM_REGS  = 32;

  function automatic int packed_width(input int ports, input int width);
    return ports * width;
  endfunction

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- one pending-write bit per architectural register.
// An issue marks its destination busy; a committed write clears the busy
// bit of its target. Register 0 is never marked busy.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active-low; clears every busy bit
//   wen      : per-write-port enables
//   wd       : packed write indices, port j at [j*AW +: AW]
//   iss_en   : issue strobe
//   iss_rd   : destination index of the issued instruction
//   busy_vec : current scoreboard state, one bit per register
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_WR   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_WR-1:0]                  wen,
  input  logic [packed_width(NUM_WR,AW)-1:0] wd,
  input  logic                               iss_en,
  input  logic [AW-1:0]                      iss_rd,
  output logic [NUM_REGS-1:0]                busy_vec
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_next;

  // The set is applied after the clear so that a new producer issued in the
  // same cycle as the old producer's write keeps the register busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wen[j] && (wd[slice_lo(j, AW) +: AW] != '0)) begin
        clr_mask[wd[slice_lo(j, AW) +: AW]] = 1'b1;
      end
    end
    if (iss_en && (iss_rd != '0)) begin
      set_mask[iss_rd] = 1'b1;
    end
    busy_next    = (busy_vec & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-ported register file with write-through bypass and a
// pending-write scoreboard. Register 0 is hardwired to zero.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active-low; clears data and scoreboard
//   rs       : packed read indices, port k at [k*AW +: AW]
//   rv       : packed read data, port k at [k*WORD_SIZE +: WORD_SIZE]
//   rbusy    : per-read-port flag, source still waiting on a producer
//   hazard   : any live read port (rs_used) sees a busy source
//   rs_used  : per-read-port liveness
//   wen      : per-write-port enables
//   wd       : packed write indices
//   wdata    : packed write data
//   iss_en   : issue strobe, marks iss_rd pending
//   iss_rd   : issued destination index
//   busy_vec : scoreboard state, one bit per register
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int NUM_REGS  = DEFAULT_NUM_REGS,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int AW        = $clog2(NUM_REGS)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [packed_width(NUM_RD,AW)-1:0]        rs,
  output logic [packed_width(NUM_RD,WORD_SIZE)-1:0] rv,
  output logic [NUM_RD-1:0]                         rbusy,
  output logic                                      hazard,
  input  logic [NUM_RD-1:0]                         rs_used,
  input  logic [NUM_WR-1:0]                         wen,
  input  logic [packed_width(NUM_WR,AW)-1:0]        wd,
  input  logic [packed_width(NUM_WR,WORD_SIZE)-1:0] wdata,
  input  logic                                      iss_en,
  input  logic [AW-1:0]                             iss_rd,
  output logic [NUM_REGS-1:0]                       busy_vec
);

  logic [WORD_SIZE-1:0] mem [NUM_REGS];

  logic [AW-1:0]        wr_idx [NUM_WR];
  logic [WORD_SIZE-1:0] wr_val [NUM_WR];
  logic [NUM_WR-1:0]    wr_live;

  // A write is live only when enabled and aimed away from register 0.
  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wr_idx[j]  = wd[slice_lo(j, AW) +: AW];
    assign wr_val[j]  = wdata[slice_lo(j, WORD_SIZE) +: WORD_SIZE];
    assign wr_live[j] = wen[j] && (wr_idx[j] != '0);
  end

  // Ports are committed in ascending order so the highest-numbered port
  // wins a same-index collision. mem[0] is reset and never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_live[j]) begin
          mem[wr_idx[j]] <= wr_val[j];
        end
      end
    end
  end

  // Combinational read with write-through bypass. The bypass loop uses the
  // same ascending priority as the commit. Reset forces zero so a write
  // presented during reset cannot leak through the bypass.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]        idx;
    logic [WORD_SIZE-1:0] val;
    logic                 hit;

    assign idx = rs[slice_lo(k, AW) +: AW];

    always_comb begin
      val = mem[idx];
      hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_live[j] && (wr_idx[j] == idx)) begin
          val = wr_val[j];
          hit = 1'b1;
        end
      end
      if (!rst || (idx == '0)) begin
        val = '0;
      end
    end

    assign rv[slice_lo(k, WORD_SIZE) +: WORD_SIZE] = val;

    // A bypassed source is already available, so it is not reported busy.
    assign rbusy[k] = rst & busy_vec[idx] & ~hit;
  end

  assign hazard = |(rbusy & rs_used);

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .wd       (wd),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- directed, table-driven bench for regfile_sb with the
// default configuration (32 x 32-bit, 2 read ports, 2 write ports).
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rs;
  logic [63:0] rv;
  logic [1:0]  rbusy;
  logic        hazard;
  logic [1:0]  rs_used;
  logic [1:0]  wen;
  logic [9:0]  wd;
  logic [63:0] wdata;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rs       (rs),
    .rv       (rv),
    .rbusy    (rbusy),
    .hazard   (hazard),
    .rs_used  (rs_used),
    .wen      (wen),
    .wd       (wd),
    .wdata    (wdata),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .busy_vec (busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: the test only waits on clock edges, this is a safety net.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wd0;
    logic [4:0]  wd1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [1:0]  rs_used;
    logic [31:0] exp_rv0;
    logic [31:0] exp_rv1;
    logic [1:0]  exp_rbusy;
    logic        exp_hazard;
    logic [31:0] exp_busy;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    wen     = v.wen;
    wd      = {v.wd1, v.wd0};
    wdata   = {v.wdata1, v.wdata0};
    iss_en  = v.iss_en;
    iss_rd  = v.iss_rd;
    rs      = {v.rs1, v.rs0};
    rs_used = v.rs_used;
  endtask

  task automatic idle_inputs();
    wen     = 2'b00;
    wd      = '0;
    wdata   = '0;
    iss_en  = 1'b0;
    iss_rd  = 5'd0;
    rs      = '0;
    rs_used = 2'b00;
  endtask

  initial begin
    // Fields: wen wd0 wd1 wdata0 wdata1 iss_en iss_rd rs0 rs1 rs_used |
    //         rv0 rv1 rbusy hazard busy_vec-after-edge
    vecs[0]  = '{2'b01, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b11,
                 32'h0, 32'h0, 2'b00, 1'b0, 32'h0};
    vecs[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b11,
                 32'h0, 32'h0, 2'b00, 1'b0, 32'h0};
    vecs[2]  = '{2'b01, 5'd5, 5'd0, 32'h12345678, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6, 2'b11,
                 32'h12345678, 32'h0, 2'b00, 1'b0, 32'h0};
    vecs[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6, 2'b11,
                 32'h12345678, 32'h0, 2'b00, 1'b0, 32'h0};
    vecs[4]  = '{2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5, 2'b11,
                 32'h22, 32'h12345678, 2'b00, 1'b0, 32'h0};
    vecs[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b11,
                 32'h22, 32'h0, 2'b00, 1'b0, 32'h0};
    vecs[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7, 2'b01,
                 32'h0, 32'h22, 2'b00, 1'b0, 32'h8};
    vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7, 2'b01,
                 32'h0, 32'h22, 2'b01, 1'b1, 32'h8};
    vecs[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd3, 2'b01,
                 32'h12345678, 32'h0, 2'b10, 1'b0, 32'h8};
    vecs[9]  = '{2'b10, 5'd0, 5'd3, 32'h0, 32'h5, 1'b0, 5'd0, 5'd3, 5'd7, 2'b01,
                 32'h5, 32'h22, 2'b00, 1'b0, 32'h0};
    vecs[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7, 2'b01,
                 32'h5, 32'h22, 2'b00, 1'b0, 32'h0};
    vecs[11] = '{2'b01, 5'd9, 5'd0, 32'hAA, 32'h0, 1'b1, 5'd9, 5'd9, 5'd3, 2'b01,
                 32'hAA, 32'h5, 2'b00, 1'b0, 32'h200};
    vecs[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3, 2'b01,
                 32'hAA, 32'h5, 2'b01, 1'b1, 32'h200};
    vecs[13] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 2'b10,
                 32'hAA, 32'hAA, 2'b11, 1'b1, 32'h200};
    vecs[14] = '{2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 2'b11,
                 32'h99, 32'h99, 2'b00, 1'b0, 32'h0};
    vecs[15] = '{2'b10, 5'd0, 5'd4, 32'h0, 32'h44, 1'b0, 5'd0, 5'd4, 5'd9, 2'b11,
                 32'h44, 32'h99, 2'b00, 1'b0, 32'h0};
    vecs[16] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd31, 5'd31, 5'd4, 2'b11,
                 32'h0, 32'h44, 2'b00, 1'b0, 32'h80000000};
    vecs[17] = '{2'b00, 5'd4, 5'd0, 32'hFFFF, 32'h0, 1'b0, 5'd0, 5'd4, 5'd31, 2'b10,
                 32'h44, 32'h0, 2'b10, 1'b1, 32'h80000000};
    vecs[18] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0, 2'b11,
                 32'h44, 32'h0, 2'b00, 1'b0, 32'h80000000};

    // Power-on reset: everything reads zero while rst is low.
    rst = 1'b0;
    idle_inputs();
    rs      = {5'd1, 5'd2};
    rs_used = 2'b11;
    #3;
    check_output("por_rv0", rv[31:0], 32'h0);
    check_output("por_rv1", rv[63:32], 32'h0);
    check_output("por_busy", busy_vec, 32'h0);
    check_output("por_hazard", 32'(hazard), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();

    // Table-driven vectors: combinational outputs before the edge,
    // scoreboard state after it.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d_rv0", i), rv[31:0], vecs[i].exp_rv0);
      check_output($sformatf("v%0d_rv1", i), rv[63:32], vecs[i].exp_rv1);
      check_output($sformatf("v%0d_rbusy", i), 32'(rbusy), 32'(vecs[i].exp_rbusy));
      check_output($sformatf("v%0d_hazard", i), 32'(hazard), 32'(vecs[i].exp_hazard));
      @(posedge clk);
      #1;
      check_output($sformatf("v%0d_busy", i), busy_vec, vecs[i].exp_busy);
    end

    // Mid-operation reset: fill some registers, issue one, then pull rst
    // low between edges with a write still presented.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      wen    = 2'b01;
      wd     = {5'd0, 5'(10 + i)};
      wdata  = {32'h0, $urandom() | 32'h1};
      iss_en = (i == 2);
      iss_rd = 5'd12;
    end
    @(posedge clk);
    #2;
    idle_inputs();
    wen     = 2'b01;
    wd      = {5'd0, 5'd5};
    wdata   = {32'h0, 32'hCAFEF00D};
    rs_used = 2'b11;
    rst     = 1'b0;
    #1;
    check_output("rst_busy", busy_vec, 32'h0);
    for (int r = 0; r < 32; r++) begin
      rs = {5'(31 - r), 5'(r)};
      #1;
      check_output($sformatf("rst_rv0_r%0d", r), rv[31:0], 32'h0);
      check_output($sformatf("rst_rv1_r%0d", r), rv[63:32], 32'h0);
      check_output($sformatf("rst_rbusy_r%0d", r), 32'(rbusy), 32'h0);
      check_output($sformatf("rst_hazard_r%0d", r), 32'(hazard), 32'h0);
    end

    // Release reset mid-cycle with a write and an issue pending; the first
    // edge with rst high must act on both.
    @(negedge clk);
    rst    = 1'b1;
    idle_inputs();
    wen    = 2'b01;
    wd     = {5'd0, 5'd6};
    wdata  = {32'h0, 32'h66};
    iss_en = 1'b1;
    iss_rd = 5'd2;
    @(posedge clk);
    #1;
    idle_inputs();
    rs      = {5'd2, 5'd6};
    rs_used = 2'b10;
    #1;
    check_output("rel_rv_r6", rv[31:0], 32'h66);
    check_output("rel_rv_r2", rv[63:32], 32'h0);
    check_output("rel_busy", busy_vec, 32'h4);
    check_output("rel_rbusy", 32'(rbusy), 32'h2);
    check_output("rel_hazard", 32'(hazard), 32'h1);

    // Edges seen while in reset must not have committed the r5 write, and
    // registers filled before reset stay cleared.
    rs = {5'd12, 5'd5};
    #1;
    check_output("rel_rv_r5", rv[31:0], 32'h0);
    check_output("rel_rv_r12", rv[63:32], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
